expu_arbiter: RTL
=================

Name: expu_arbiter

Overview:
- Shares one enable-gated exponential datapath (Schraudolph stage plus optional mantissa correction, fixed latency in enabled cycles) between NUM_REQ requesters.
- Round-robin arbitration issues one operand per enabled cycle.
- A shadow shift register tracks the owner tag of every in-flight operand and returns each result to its owner with a valid/ready handshake.
- A response that is not accepted stalls the whole datapath by dropping exp_enable_o.

Parameters:
- NUM_REQ, 4, number of requesters, ≥2.
- WIDTH, 16, float width (MANTISSA_BITS+EXPONENT_BITS+1 of the datapath).
- LATENCY, 2, datapath latency in enabled cycles: 1 when correction is disabled, 2 when enabled. Must be ≥1.
- TAG_W, $clog2(NUM_REQ), owner tag width (localparam).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous flush
- req_valid_i  in  NUM_REQ  per-requester operand valid
- req_ready_o  out  NUM_REQ  per-requester operand accepted
- req_data_i  in  NUM_REQ*WIDTH  operands; requester i at slice [i*WIDTH +: WIDTH]
- rsp_valid_o  out  NUM_REQ  result valid, one-hot or zero
- rsp_ready_i  in  NUM_REQ  per-requester result accept
- rsp_data_o  out  WIDTH  result, broadcast to all requesters
- exp_enable_o  out  1  to datapath enable_i
- exp_clear_o  out  1  to datapath clear_i
- exp_float_o  out  WIDTH  to datapath float_i
- exp_float_i  in  WIDTH  from datapath float_o

Behaviour:
- Reset:
  - All shadow valids, tags and the RR pointer go to 0.
  - req_ready_o=0, rsp_valid_o=0.
  - exp_enable_o=1 (no valid at the output stage, so no stall), exp_clear_o=0.
- Shadow pipeline: v[0..LATENCY-1] and tag[0..LATENCY-1].
  - On each edge with exp_enable_o=1: v[0]<=issue, tag[0]<=grant index, v[k]<=v[k-1], tag[k]<=tag[k-1].
  - With exp_enable_o=0, contents are held.
- Output stage:
  - head = v[LATENCY-1], owner = tag[LATENCY-1].
  - rsp_valid_o[owner]=head; all other bits 0.
  - rsp_data_o=exp_float_i, passed through combinationally.
- Stall: stall = head & ~rsp_ready_i[owner]. exp_enable_o = ~stall & ~clear_i.
- Arbitration (combinational, only when exp_enable_o=1):
  - Search req_valid_i starting at the RR pointer, wrapping modulo NUM_REQ.
  - The first set index g is granted: req_ready_o = one-hot(g); issue=1; exp_float_o = req_data_i[g].
  - No request: issue=0, req_ready_o=0, exp_float_o=0; a bubble enters the pipeline.
  - When exp_enable_o=0: req_ready_o=0, and exp_float_o still shows the candidate operand (don't-care to the datapath).
- RR pointer:
  - On an issuing edge, pointer <= (g+1) mod NUM_REQ.
  - Otherwise held.
  - Wrap from NUM_REQ-1 to 0.
- Latency: an operand accepted at edge t is presented at rsp_valid_o after exactly LATENCY further enabled edges.
- Throughput: 1 operand/cycle when all responses are accepted immediately.
- Ordering: results return in issue order, globally and per requester.
- Simultaneous response accept and new issue in the same cycle is allowed. This is the steady-state pipelined case.
- A requester may hold req_valid_i while waiting; data must be stable until req_ready_o.
- clear_i:
  - exp_clear_o=clear_i, combinational.
  - On the edge: all v cleared, RR pointer reset to 0, no grant (req_ready_o=0 during clear).
  - In-flight results are discarded, including a stalled head.
- Reset mid-operation: in-flight operations are lost and no rsp_valid_o is asserted afterwards.

Test Plan:
- Single op, datapath stub (LATENCY-stage enabled delay, out = in ^ 0x5A5A): requester 2 sends 0x3F80 with rsp_ready all 1 → req_ready_o=0b0100 in the same cycle; 2 cycles later rsp_valid_o=0b0100, rsp_data_o=0x65DA.
- All 4 requesters continuously valid, ready all 1 → grants 0,1,2,3,0,… one per cycle; responses arrive in the same order 2 cycles later; no bubbles.
- Backpressure: requester 1's result head with rsp_ready_i[1]=0 for 3 cycles → exp_enable_o=0 and req_ready_o=0 for 3 cycles; the shadow is held; the result is delivered when ready=1, then the next result follows the next cycle.
- Sparse requests: only requester 3 valid, then requester 0 → grant 3, pointer to 0, grant 0; a cycle with no valids inserts a bubble and no rsp_valid 2 cycles later.
- clear_i pulse with 2 ops in flight and one stalled → exp_clear_o=1 that cycle; afterwards rsp_valid_o=0 and the RR pointer is 0 (next grant goes to the lowest valid index).
- Async reset asserted with ops in flight → rsp_valid_o=0 and req_ready_o=0 immediately; after release, a first op from requester 0 completes with latency 2.

Source files
------------

// File: rtl/expu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : expu_arbiter
// Purpose  : Round-robin sharing of one enable-gated exp datapath between
//            NUM_REQ requesters, with owner-tag shadow pipeline for returns.
// Revision : 1.0 - initial release
// ============================================================================
module expu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    input  logic [NUM_REQ-1:0]       rsp_ready_i,
    output logic [WIDTH-1:0]         rsp_data_o,
    output logic                     exp_enable_o,
    output logic                     exp_clear_o,
    output logic [WIDTH-1:0]         exp_float_o,
    input  logic [WIDTH-1:0]         exp_float_i
);

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [LATENCY-1:0]            v_q, v_d;
    logic [LATENCY-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0]              ptr_q, ptr_d;

    logic             head;
    logic [TAG_W-1:0] owner;
    logic             stall;
    logic             grant_found;
    logic [TAG_W-1:0] grant_idx;
    logic [TAG_W:0]   cand;
    logic             issue;

    assign head         = v_q[LATENCY-1];
    assign owner        = tag_q[LATENCY-1];
    assign stall        = head & ~rsp_ready_i[owner];
    assign exp_enable_o = ~stall & ~clear_i;
    assign exp_clear_o  = clear_i;
    assign rsp_data_o   = exp_float_i;

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (TAG_W+1)'(k);
            if (cand >= (TAG_W+1)'(NUM_REQ)) begin
                cand = cand - (TAG_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid_i[cand[TAG_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[TAG_W-1:0];
            end
        end
    end

    // No grant while reset is held so requesters never see a lost handshake
    assign issue       = grant_found & exp_enable_o & rst_ni;
    assign exp_float_o = grant_found ? req_data_i[grant_idx*WIDTH +: WIDTH] : '0;

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = issue && (grant_idx == TAG_W'(i));
            rsp_valid_o[i] = head && (owner == TAG_W'(i));
        end
    end

    always_comb begin
        v_d   = v_q;
        tag_d = tag_q;
        ptr_d = ptr_q;
        if (clear_i) begin
            v_d   = '0;
            ptr_d = '0;
        end else if (exp_enable_o) begin
            v_d[0]   = issue;
            tag_d[0] = grant_idx;
            for (int k = 1; k < LATENCY; k++) begin
                v_d[k]   = v_q[k-1];
                tag_d[k] = tag_q[k-1];
            end
            if (issue) begin
                ptr_d = (grant_idx == TAG_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q   <= '0;
            tag_q <= '0;
            ptr_q <= '0;
        end else begin
            v_q   <= v_d;
            tag_q <= tag_d;
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire
